// File: rtl/cheri_tbre_pkg.sv
// Package: cheri_tbre_pkg
// Shared types for the tag background revocation engine.
// - reg_cap_t    : compressed capability metadata carried beside a 32-bit data word.
// - NULL_REG_CAP : all-zero, untagged capability.
package cheri_tbre_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  exp;
        logic [8:0]  top;
        logic [8:0]  base;
        logic [3:0]  otype;
        logic [11:0] cperms;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '{
        valid:  1'b0,
        exp:    5'd0,
        top:    9'd0,
        base:   9'd0,
        otype:  4'd0,
        cperms: 12'd0
    };

endpackage

// File: rtl/cheri_tbre.sv
// Module: cheri_tbre
// Tag background revocation engine. Walks [start, end) one 8-byte capability
// granule at a time through the LSU:
// - It loads the granule.
// - It waits for the revocation-check stage to report on it.
// - If the granule is revoked, it writes the granule back with the tag cleared.
// A CPU store to the granule between the load response and the write-back makes
// the loaded copy stale, so the engine reloads the granule instead of storing it.
//
// Optional feature: define CHERI_TBRE_STATS_EN to get a saturating count of
// successful revocation write-backs on tbre_nrevoked_o. Otherwise that output
// is tied to zero and no counter exists.
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   tbre_start_i / tbre_stop_i  sweep start pulse / abort request
//   tbre_start_addr_i           first address of the range (inclusive)
//   tbre_end_addr_i             end address of the range (exclusive)
//   tbre_busy_o, tbre_done_o    sweep in progress / one-cycle end-of-sweep pulse
//   tbre_err_o                  sticky LSU error flag for the current sweep
//   tbre_lsu_*_o                LSU request: req, we, addr, wdata, wcap
//   lsu_tbre_*_i                LSU accept, response valid, response error
//   rf_wdata_lsu_i              loaded data word
//   rf_wcap_lsu_i               loaded capability metadata
//   tbre_trvk_en_i              revocation-stage result valid
//   tbre_trvk_clrtag_i          revocation-stage "revoked" flag
//   cpu_wr_valid_i              CPU store snoop: valid
//   cpu_wr_addr_i               CPU store snoop: address
//   tbre_nrevoked_o             revoked-granule counter
module cheri_tbre
    import cheri_tbre_pkg::*;
#(
    parameter int unsigned StatsWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tbre_start_i,
    input  logic                  tbre_stop_i,
    input  logic [31:0]           tbre_start_addr_i,
    input  logic [31:0]           tbre_end_addr_i,
    output logic                  tbre_busy_o,
    output logic                  tbre_done_o,
    output logic                  tbre_err_o,
    output logic                  tbre_lsu_req_o,
    output logic                  tbre_lsu_we_o,
    output logic [31:0]           tbre_lsu_addr_o,
    output logic [31:0]           tbre_lsu_wdata_o,
    output reg_cap_t              tbre_lsu_wcap_o,
    input  logic                  lsu_tbre_req_done_i,
    input  logic                  lsu_tbre_resp_valid_i,
    input  logic                  lsu_tbre_resp_err_i,
    input  logic [31:0]           rf_wdata_lsu_i,
    input  reg_cap_t              rf_wcap_lsu_i,
    input  logic                  tbre_trvk_en_i,
    input  logic                  tbre_trvk_clrtag_i,
    input  logic                  cpu_wr_valid_i,
    input  logic [31:0]           cpu_wr_addr_i,
    output logic [StatsWidth-1:0] tbre_nrevoked_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_REQ    = 3'd1,
        LD_WAIT   = 3'd2,
        TRVK_WAIT = 3'd3,
        ST_REQ    = 3'd4,
        ST_WAIT   = 3'd5,
        NEXT      = 3'd6
    } tbre_state_e;

    tbre_state_e state_r;

    // Pointers are kept as granule indices (address bits [31:3]).
    logic [28:0] gran_ptr_r;
    logic [28:0] gran_end_r;
    logic        stop_r;
    logic        snoop_hit_r;
    logic [31:0] ld_data_r;
    reg_cap_t    ld_cap_r;

    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        req_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    reg_cap_t    wcap_r;

    logic [28:0] start_gran_s;
    logic [28:0] end_gran_s;
    logic [29:0] gran_nxt_s;
    logic        sweep_last_s;
    logic        cpu_hit_s;
    reg_cap_t    wb_cap_s;
    logic        unused_s;

    assign start_gran_s = tbre_start_addr_i[31:3];
    assign end_gran_s   = tbre_end_addr_i[31:3];

    // Bit 29 of the incremented pointer flags a wrap past the top of memory.
    assign gran_nxt_s   = {1'b0, gran_ptr_r} + 30'd1;
    assign sweep_last_s = stop_r | gran_nxt_s[29] | (gran_nxt_s[28:0] >= gran_end_r);
    assign cpu_hit_s    = cpu_wr_valid_i & (cpu_wr_addr_i[31:3] == gran_ptr_r);

    // The byte offset and the loaded tag bit play no part in the sweep.
    assign unused_s = ^{tbre_start_addr_i[2:0], tbre_end_addr_i[2:0],
                        cpu_wr_addr_i[2:0], ld_cap_r.valid};

    // Write-back capability: the loaded metadata with its tag cleared.
    always_comb begin
        wb_cap_s       = ld_cap_r;
        wb_cap_s.valid = 1'b0;
    end

    // Sweep FSM. All LSU-facing and status outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            gran_ptr_r  <= 29'd0;
            gran_end_r  <= 29'd0;
            stop_r      <= 1'b0;
            snoop_hit_r <= 1'b0;
            ld_data_r   <= 32'd0;
            ld_cap_r    <= NULL_REG_CAP;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            wcap_r      <= NULL_REG_CAP;
        end else begin
            done_r <= 1'b0;
            // An abort request is remembered for the whole sweep and only acted on in NEXT.
            if ((state_r != IDLE) && tbre_stop_i) begin
                stop_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    stop_r <= tbre_start_i & tbre_stop_i;
                    if (tbre_start_i) begin
                        gran_ptr_r <= start_gran_s;
                        gran_end_r <= end_gran_s;
                        err_r      <= 1'b0;
                        if (start_gran_s >= end_gran_s) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r     <= LD_REQ;
                            busy_r      <= 1'b1;
                            req_r       <= 1'b1;
                            we_r        <= 1'b0;
                            addr_r      <= {start_gran_s, 3'b000};
                            snoop_hit_r <= 1'b0;
                        end
                    end
                end
                LD_REQ: begin
                    if (lsu_tbre_req_done_i) begin
                        req_r   <= 1'b0;
                        state_r <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (lsu_tbre_resp_valid_i) begin
                        ld_data_r   <= rf_wdata_lsu_i;
                        ld_cap_r    <= rf_wcap_lsu_i;
                        snoop_hit_r <= cpu_hit_s;
                        if (lsu_tbre_resp_err_i) begin
                            err_r <= 1'b1;
                        end
                        state_r <= TRVK_WAIT;
                    end
                end
                TRVK_WAIT: begin
                    snoop_hit_r <= snoop_hit_r | cpu_hit_s;
                    if (tbre_trvk_en_i) begin
                        if (tbre_trvk_clrtag_i && (snoop_hit_r || cpu_hit_s)) begin
                            // The CPU overwrote the granule: the loaded copy is stale, so reload it.
                            state_r     <= LD_REQ;
                            req_r       <= 1'b1;
                            we_r        <= 1'b0;
                            addr_r      <= {gran_ptr_r, 3'b000};
                            snoop_hit_r <= 1'b0;
                        end else if (tbre_trvk_clrtag_i) begin
                            state_r <= ST_REQ;
                            req_r   <= 1'b1;
                            we_r    <= 1'b1;
                            addr_r  <= {gran_ptr_r, 3'b000};
                            wdata_r <= ld_data_r;
                            wcap_r  <= wb_cap_s;
                        end else begin
                            state_r <= NEXT;
                        end
                    end
                end
                ST_REQ: begin
                    if (lsu_tbre_req_done_i) begin
                        req_r   <= 1'b0;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lsu_tbre_resp_valid_i) begin
                        if (lsu_tbre_resp_err_i) begin
                            err_r <= 1'b1;
                        end
                        state_r <= NEXT;
                    end
                end
                NEXT: begin
                    gran_ptr_r <= gran_nxt_s[28:0];
                    if (sweep_last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r     <= LD_REQ;
                        req_r       <= 1'b1;
                        we_r        <= 1'b0;
                        addr_r      <= {gran_nxt_s[28:0], 3'b000};
                        snoop_hit_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    req_r   <= 1'b0;
                    we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign tbre_busy_o      = busy_r;
    assign tbre_done_o      = done_r;
    assign tbre_err_o       = err_r;
    assign tbre_lsu_req_o   = req_r;
    assign tbre_lsu_we_o    = we_r;
    assign tbre_lsu_addr_o  = addr_r;
    assign tbre_lsu_wdata_o = wdata_r;
    assign tbre_lsu_wcap_o  = wcap_r;

`ifdef CHERI_TBRE_STATS_EN
    logic [StatsWidth-1:0] nrevoked_r;
    logic                  wb_ok_s;

    // A write-back counts only once the LSU reports it completed cleanly.
    assign wb_ok_s = (state_r == ST_WAIT) & lsu_tbre_resp_valid_i & ~lsu_tbre_resp_err_i;

    // Saturating revoked-granule counter, cleared when a sweep is launched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nrevoked_r <= {StatsWidth{1'b0}};
        end else if ((state_r == IDLE) && tbre_start_i) begin
            nrevoked_r <= {StatsWidth{1'b0}};
        end else if (wb_ok_s && (nrevoked_r != {StatsWidth{1'b1}})) begin
            nrevoked_r <= nrevoked_r + {{(StatsWidth-1){1'b0}}, 1'b1};
        end
    end

    assign tbre_nrevoked_o = nrevoked_r;
`else
    assign tbre_nrevoked_o = {StatsWidth{1'b0}};
`endif

endmodule
